framebuffer_swapchain: RTL and testbench
========================================

// Module: framebuffer_swapchain
// PURPOSE
//  Parametrised double-buffered framebuffer between the renderer and the VGA output path.
//  The renderer draws into the back buffer while the output module reads the front buffer.
//  Buffers swap on the first new_frame after render_done, then the new back buffer is cleared.
//  Adds over the previous generation: generic geometry and colour depth, runtime clear colour,
//  bounds-checked writes and reads, and a dropped-frame indication.
// PARAMETERS
//  WIDTH        320  pixels per line
//  HEIGHT       240  lines per frame
//  CBITS        3    bits per pixel
//  COLORKEY     0    write-skip colour; used only when FB_COLORKEY_EN is defined
//  (localparams: DEPTH=WIDTH*HEIGHT, AW=$clog2(DEPTH), XW=$clog2(WIDTH), YW=$clog2(HEIGHT))
// PORTS
//  Clk           in   1      system clock
//  Reset         in   1      synchronous, active-high reset
//  new_frame     in   1      one-cycle pulse at vsync
//  out_x/out_y   in   XW/YW  output-module pixel coordinates
//  color_out     out  CBITS  front-buffer pixel, 1-cycle read latency
//  rend_x/rend_y in   XW/YW  renderer pixel coordinates
//  color_in      in   CBITS  renderer write data
//  we            in   1      renderer write enable
//  render_done   in   1      renderer has finished the current frame
//  clear_color   in   CBITS  fill value; sampled when a CLEAR starts
//  render_ack    out  1      one-cycle pulse: back buffer is cleared and the renderer may draw
//  frame_dropped out  1      one-cycle pulse: new_frame seen before the swap was possible
//  front_sel     out  1      index of the buffer currently displayed
// BEHAVIOUR
//  - Reset values: state=CLEAR, clear counter=0, front_sel=0, render_ack=0, frame_dropped=0,
//    color_out=0. clear_color is latched in the cycle Reset is sampled. Reset mid-clear restarts the clear.
//  - Addressing: addr = y*WIDTH + x, computed AW bits wide.
//  - Out-of-range coordinates (x>=WIDTH or y>=HEIGHT):
//    - writes are dropped;
//    - reads return 0 on the next cycle.
//  - Reads: color_out <= front[out addr] every cycle, in all states.
//  - CLEAR:
//    - writes the latched clear colour into back[ctr], ctr increments by 1 per cycle;
//    - when ctr==DEPTH-1: write the last pixel, go to RENDER, pulse render_ack for 1 cycle;
//    - a full clear takes exactly DEPTH cycles;
//    - we and render_done are ignored.
//  - RENDER:
//    - when we=1, back[rend addr] <= color_in;
//    - render_done moves to WAIT_VSYNC; if we is also high in that cycle, the write still occurs.
//  - WAIT_VSYNC:
//    - new_frame causes front_sel to toggle, ctr=0, clear_color is re-latched, state goes to CLEAR;
//    - the swap takes effect for reads on the following cycle;
//    - we is ignored.
//  - new_frame while in CLEAR or RENDER: no swap, frame_dropped pulses 1 cycle,
//    front buffer is unchanged.
//  - Simultaneous render_done and new_frame while in RENDER: counts as a drop; the swap happens
//    on the next new_frame.
// CONFIGURATION
//  FB_COLORKEY_EN defined:
//    - RENDER writes with color_in==COLORKEY are suppressed, giving transparent sprites;
//    - CLEAR is unaffected.
//  FB_COLORKEY_EN undefined: every in-range write with we=1 is stored; COLORKEY is unused.
// TESTING
//  1. Reset, clear_color=5, run DEPTH cycles -> render_ack pulses once at cycle DEPTH;
//     after the swap every front pixel reads 5.
//  2. Write (10,2)=3, render_done, new_frame -> front_sel=1; read (10,2) -> 3 after 1 cycle;
//     (11,2) -> 5.
//  3. Write at x=WIDTH, y=0 and at y=HEIGHT -> no pixel changes; reading (WIDTH,0) returns 0.
//  4. new_frame during CLEAR and during RENDER -> frame_dropped pulses each time;
//     front_sel is unchanged.
//  5. Assert Reset mid-CLEAR at ctr=1000 -> state=CLEAR, ctr=0, render_ack=0;
//     the clear completes DEPTH cycles later.
//  6. FB_COLORKEY_EN, COLORKEY=0: write (4,4)=0 over a clear of 5 -> reads 5;
//     without the macro -> reads 0.

Source files
------------

// File: rtl/framebuffer_swapchain.sv
// Double-buffered framebuffer: the renderer draws into the back buffer while the display reads the front.
// Optional build macro FB_COLORKEY_EN: renderer writes whose colour equals COLORKEY are skipped.
module framebuffer_swapchain #(
  parameter int WIDTH    = 320,
  parameter int HEIGHT   = 240,
  parameter int CBITS    = 3,
  parameter int COLORKEY = 0,
  localparam int DEPTH = WIDTH * HEIGHT,
  localparam int AW    = $clog2(DEPTH),
  localparam int XW    = $clog2(WIDTH),
  localparam int YW    = $clog2(HEIGHT)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             new_frame,
  input  logic [XW-1:0]    out_x,
  input  logic [YW-1:0]    out_y,
  output logic [CBITS-1:0] color_out,
  input  logic [XW-1:0]    rend_x,
  input  logic [YW-1:0]    rend_y,
  input  logic [CBITS-1:0] color_in,
  input  logic             we,
  input  logic             render_done,
  input  logic [CBITS-1:0] clear_color,
  output logic             render_ack,
  output logic             frame_dropped,
  output logic             front_sel
);

  typedef enum logic [1:0] {CLEAR, RENDER, WAIT_VSYNC} state_t;

  state_t           state;
  logic [AW-1:0]    ctr;
  logic [CBITS-1:0] clear_lat;
  logic [CBITS-1:0] buf0 [DEPTH];
  logic [CBITS-1:0] buf1 [DEPTH];

  logic [AW-1:0]    rend_addr;
  logic [AW-1:0]    out_addr;
  logic             rend_ok;
  logic             out_ok;
  logic             key_skip;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [CBITS-1:0] wr_data;

  assign rend_ok   = (int'(rend_x) < WIDTH) && (int'(rend_y) < HEIGHT);
  assign out_ok    = (int'(out_x) < WIDTH) && (int'(out_y) < HEIGHT);
  assign rend_addr = AW'(rend_y) * AW'(WIDTH) + AW'(rend_x);
  assign out_addr  = AW'(out_y) * AW'(WIDTH) + AW'(out_x);

`ifdef FB_COLORKEY_EN
  assign key_skip = (color_in == CBITS'(COLORKEY));
`else
  // The key compare is masked off so COLORKEY stays referenced in the plain build
  assign key_skip = 1'b0 & (color_in == CBITS'(COLORKEY));
`endif

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = ctr;
    wr_data = clear_lat;
    if (!Reset) begin
      case (state)
        CLEAR:  wr_en = 1'b1;
        RENDER: begin
          if (we && rend_ok && !key_skip) begin
            wr_en   = 1'b1;
            wr_addr = rend_addr;
            wr_data = color_in;
          end
        end
        default: wr_en = 1'b0;
      endcase
    end
  end

  // Back buffer is always the one not selected for display
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      if (front_sel) buf0[wr_addr] <= wr_data;
      else           buf1[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state         <= CLEAR;
      ctr           <= '0;
      front_sel     <= 1'b0;
      render_ack    <= 1'b0;
      frame_dropped <= 1'b0;
      color_out     <= '0;
      clear_lat     <= clear_color;
    end else begin
      color_out     <= out_ok ? (front_sel ? buf1[out_addr] : buf0[out_addr]) : '0;
      render_ack    <= 1'b0;
      frame_dropped <= 1'b0;
      case (state)
        CLEAR: begin
          frame_dropped <= new_frame;
          if (ctr == AW'(DEPTH - 1)) begin
            state      <= RENDER;
            render_ack <= 1'b1;
          end else begin
            ctr <= ctr + AW'(1);
          end
        end
        RENDER: begin
          frame_dropped <= new_frame;
          if (render_done) state <= WAIT_VSYNC;
        end
        WAIT_VSYNC: begin
          if (new_frame) begin
            front_sel <= ~front_sel;
            ctr       <= '0;
            clear_lat <= clear_color;
            state     <= CLEAR;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_framebuffer_swapchain.sv
// Testbench for framebuffer_swapchain: directed sequences, a read-vector table and a randomized run
// against a frame-level reference model. Honours FB_COLORKEY_EN the same way the design does.
module tb_framebuffer_swapchain;

  localparam int WIDTH    = 20;
  localparam int HEIGHT   = 10;
  localparam int CBITS    = 3;
  localparam int COLORKEY = 0;
  localparam int DEPTH    = WIDTH * HEIGHT;
  localparam int XW       = $clog2(WIDTH);
  localparam int YW       = $clog2(HEIGHT);
`ifdef FB_COLORKEY_EN
  localparam int KEY_EXP  = 5;
`else
  localparam int KEY_EXP  = COLORKEY;
`endif

  logic             Clk = 1'b0;
  logic             Reset;
  logic             new_frame;
  logic [XW-1:0]    out_x;
  logic [YW-1:0]    out_y;
  logic [CBITS-1:0] color_out;
  logic [XW-1:0]    rend_x;
  logic [YW-1:0]    rend_y;
  logic [CBITS-1:0] color_in;
  logic             we;
  logic             render_done;
  logic [CBITS-1:0] clear_color;
  logic             render_ack;
  logic             frame_dropped;
  logic             front_sel;

  framebuffer_swapchain #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .CBITS(CBITS), .COLORKEY(COLORKEY)
  ) dut (
    .Clk(Clk), .Reset(Reset), .new_frame(new_frame), .out_x(out_x), .out_y(out_y),
    .color_out(color_out), .rend_x(rend_x), .rend_y(rend_y), .color_in(color_in), .we(we),
    .render_done(render_done), .clear_color(clear_color), .render_ack(render_ack),
    .frame_dropped(frame_dropped), .front_sel(front_sel)
  );

  always #5 Clk = ~Clk;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    int x;
    int y;
    bit nf;
    int expColor;
    bit expDrop;
  } readVec_t;

  readVec_t vecs [12];

  // Frame-level reference model: buffers as plain arrays, a clear modelled as a countdown
  // after which the whole back buffer takes the latched colour at once.
  logic [CBITS-1:0] mBuf [2][DEPTH];
  int               mFront;
  int               mClearLeft;
  bit               mWaiting;
  bit               mFrontValid;
  int               mLatch;
  int               expColor;
  bit               colorKnown;
  bit               expAck;
  bit               expDrop;

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit nf, input bit w, input bit rd,
                               input int rx, input int ry, input int ci, input int cc,
                               input int ox, input int oy);
    Reset       = rst;
    new_frame   = nf;
    we          = w;
    render_done = rd;
    rend_x      = XW'(rx);
    rend_y      = YW'(ry);
    color_in    = CBITS'(ci);
    clear_color = CBITS'(cc);
    out_x       = XW'(ox);
    out_y       = YW'(oy);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic modelStep(input bit rst, input bit nf, input bit w, input bit rd,
                           input int rx, input int ry, input int ci, input int cc,
                           input int ox, input int oy);
    bit outIn;
    bit keyOk;
    outIn      = (ox < WIDTH) && (oy < HEIGHT);
    expColor   = outIn ? int'(mBuf[mFront][oy * WIDTH + ox]) : 0;
    colorKnown = !outIn || mFrontValid;
`ifdef FB_COLORKEY_EN
    keyOk = (ci != COLORKEY);
`else
    keyOk = 1'b1;
`endif
    expAck  = 1'b0;
    expDrop = 1'b0;
    if (rst) begin
      mFront      = 0;
      mClearLeft  = DEPTH;
      mWaiting    = 1'b0;
      mFrontValid = 1'b0;
      mLatch      = cc;
      expColor    = 0;
      colorKnown  = 1'b1;
    end else if (mClearLeft > 0) begin
      expDrop = nf;
      mClearLeft--;
      if (mClearLeft == 0) begin
        expAck = 1'b1;
        for (int a = 0; a < DEPTH; a++) mBuf[1 - mFront][a] = CBITS'(mLatch);
      end
    end else if (!mWaiting) begin
      expDrop = nf;
      if (w && rx < WIDTH && ry < HEIGHT && keyOk) mBuf[1 - mFront][ry * WIDTH + rx] = CBITS'(ci);
      if (rd) mWaiting = 1'b1;
    end else if (nf) begin
      mFront      = 1 - mFront;
      mFrontValid = 1'b1;
      mWaiting    = 1'b0;
      mClearLeft  = DEPTH;
      mLatch      = cc;
    end
  endtask

  initial begin
    int ackCount;
    int ackAt;
    bit rst, nf, w, rd;
    int rx, ry, ci, cc, ox, oy;

    vecs[0]  = '{10, 2, 1'b0, 3, 1'b0};
    vecs[1]  = '{11, 2, 1'b1, 5, 1'b1};
    vecs[2]  = '{0, 0, 1'b0, 5, 1'b0};
    vecs[3]  = '{0, 2, 1'b0, 5, 1'b0};
    vecs[4]  = '{0, 1, 1'b0, 5, 1'b0};
    vecs[5]  = '{19, 9, 1'b0, 6, 1'b0};
    vecs[6]  = '{4, 4, 1'b0, KEY_EXP, 1'b0};
    vecs[7]  = '{WIDTH, 0, 1'b0, 0, 1'b0};
    vecs[8]  = '{5, HEIGHT, 1'b1, 0, 1'b1};
    vecs[9]  = '{31, 15, 1'b0, 0, 1'b0};
    vecs[10] = '{3, 9, 1'b0, 5, 1'b0};
    vecs[11] = '{19, 0, 1'b0, 5, 1'b0};

    // Reset with clear colour 5, then a full clear with stray we/render_done that must be ignored
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 5, 0, 0);
    tick();
    checkOutput("reset_front_sel", front_sel, 0);
    checkOutput("reset_render_ack", render_ack, 0);
    checkOutput("reset_frame_dropped", frame_dropped, 0);
    checkOutput("reset_color_out", color_out, 0);

    ackCount = 0;
    ackAt    = -1;
    for (int c = 1; c <= DEPTH + 5; c++) begin
      if (c == 1) applyStimulus(0, 0, 1, 1, 0, 0, 7, 2, 0, 0);
      if (c == DEPTH + 1) applyStimulus(0, 0, 0, 0, 0, 0, 0, 2, 0, 0);
      tick();
      if (render_ack) begin
        ackCount++;
        if (ackAt < 0) ackAt = c;
      end
    end
    checkOutput("clear_ack_count", ackCount, 1);
    checkOutput("clear_ack_cycle", ackAt, DEPTH);

    // Render: one good write, two out-of-range writes, a colour-key write, a dropped frame
    applyStimulus(0, 0, 1, 0, 10, 2, 3, 2, 0, 0);       tick();
    applyStimulus(0, 0, 1, 0, WIDTH, 1, 7, 2, 0, 0);    tick();
    applyStimulus(0, 0, 1, 0, 3, HEIGHT, 7, 2, 0, 0);   tick();
    applyStimulus(0, 0, 1, 0, 4, 4, COLORKEY, 2, 0, 0); tick();
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 2, 0, 0);        tick();
    checkOutput("render_drop_pulse", frame_dropped, 1);
    checkOutput("render_drop_front_sel", front_sel, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 2, 0, 0);        tick();
    checkOutput("render_drop_ends", frame_dropped, 0);
    applyStimulus(0, 0, 1, 1, 19, 9, 6, 2, 0, 0);       tick();
    applyStimulus(0, 0, 1, 0, 11, 2, 7, 2, 0, 0);       tick();
    checkOutput("wait_front_sel", front_sel, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 6, 0, 0);        tick();
    checkOutput("swap_front_sel", front_sel, 1);
    checkOutput("swap_no_drop", frame_dropped, 0);

    // Read the new front buffer while the back buffer clears
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, vecs[i].nf, 0, 0, 0, 0, 0, 6, vecs[i].x, vecs[i].y);
      tick();
      checkOutput($sformatf("vec%0d_color(%0d,%0d)", i, vecs[i].x, vecs[i].y), color_out, vecs[i].expColor);
      checkOutput($sformatf("vec%0d_drop", i), frame_dropped, vecs[i].expDrop);
    end
    checkOutput("clear_front_sel_held", front_sel, 1);

    // Reset in the middle of a clear restarts it from the first pixel
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 6, 0, 0);
    for (int c = 0; c < 50; c++) tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    checkOutput("midclear_reset_ack", render_ack, 0);
    checkOutput("midclear_reset_front_sel", front_sel, 0);
    checkOutput("midclear_reset_color_out", color_out, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    ackAt = -1;
    for (int c = 1; c <= 3 * DEPTH && ackAt < 0; c++) begin
      tick();
      if (render_ack) ackAt = c;
    end
    checkOutput("midclear_restart_ack_cycle", ackAt, DEPTH);

    // Randomized run against the reference model
    for (int i = 0; i < 4000; i++) begin
      rst = (i == 0) || ($urandom_range(0, 799) == 0);
      nf  = ($urandom_range(0, 9) == 0);
      w   = $urandom_range(0, 1) == 1;
      rd  = ($urandom_range(0, 11) == 0);
      rx  = $urandom_range(0, WIDTH + 3);
      ry  = $urandom_range(0, HEIGHT + 2);
      ci  = $urandom_range(0, (1 << CBITS) - 1);
      cc  = $urandom_range(0, (1 << CBITS) - 1);
      ox  = $urandom_range(0, WIDTH + 3);
      oy  = $urandom_range(0, HEIGHT + 2);
      applyStimulus(rst, nf, w, rd, rx, ry, ci, cc, ox, oy);
      modelStep(rst, nf, w, rd, rx, ry, ci, cc, ox, oy);
      tick();
      checkOutput($sformatf("rand%0d_front_sel", i), front_sel, mFront);
      checkOutput($sformatf("rand%0d_render_ack", i), render_ack, expAck);
      checkOutput($sformatf("rand%0d_frame_dropped", i), frame_dropped, expDrop);
      if (colorKnown)
        checkOutput($sformatf("rand%0d_color(%0d,%0d)", i, ox, oy), color_out, expColor);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
